// File: rtl/fft_pkg.sv
// Shared FFT types and helpers for the output-stage serialiser.
// Optional build macro used by consumers: P2S_BITREV_EN (bit-reversed lane order).
package fft_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned FFT_N    = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < width; i++) begin
      r[width-1-i] = idx[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/p2s_stream_if.sv
// Frame-in / sample-out stream bundle for p2s_stream; master drives frames and
// accepts samples, slave is the serialiser.
interface p2s_stream_if
  import fft_pkg::*;
#(
  parameter int unsigned W = SAMPLE_W,
  parameter int unsigned N = FFT_N
);
  localparam int unsigned IW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_idx;
  logic          out_first;
  logic          out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_first, out_last
  );

endinterface

// File: rtl/p2s_lane_sel.sv
// N:1 lane mux for the serialiser; beat counter maps to lane directly or,
// under P2S_BITREV_EN, through bit reversal so FFT bins leave in natural order.
module p2s_lane_sel
  import fft_pkg::*;
#(
  parameter int unsigned W = SAMPLE_W,
  parameter int unsigned N = FFT_N,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N*W-1:0] frame,
  input  logic [IW-1:0]  cnt,
  output logic [W-1:0]   data,
  output logic [IW-1:0]  idx
);

  always_comb begin
`ifdef P2S_BITREV_EN
    idx = IW'(bitrev(32'(cnt), IW));
`else
    idx = cnt;
`endif
    data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == IW'(i)) data = frame[i*W +: W];
    end
  end

endmodule

// File: rtl/p2s_stream.sv
// Parallel-to-serial converter: one N-lane frame per handshake out as N beats,
// with a one-frame pending buffer for bubble-free streaming. Macro: P2S_BITREV_EN.
module p2s_stream
  import fft_pkg::*;
#(
  parameter int unsigned W = SAMPLE_W,
  parameter int unsigned N = FFT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  p2s_stream_if.slave  st,
  output logic         busy
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N-1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t         state;
  logic [IW-1:0]  cnt;
  logic [N*W-1:0] shift_q;
  logic [N*W-1:0] pend_q;
  logic           pend_full;
  logic           ifire;
  logic           ofire;
  logic           done;

  assign st.in_ready  = rst_n && !pend_full;
  assign ifire        = st.in_valid && st.in_ready;
  assign st.out_valid = (state == STREAM);
  assign ofire        = st.out_valid && st.out_ready;
  assign done         = ofire && (cnt == LAST);
  assign st.out_first = st.out_valid && (cnt == '0);
  assign st.out_last  = st.out_valid && (cnt == LAST);
  assign busy         = st.out_valid || pend_full;

  // Shift stage is zeroed whenever it empties so out_data/out_idx read 0 when idle.
  p2s_lane_sel #(.W(W), .N(N)) u_sel (
    .frame (shift_q),
    .cnt   (cnt),
    .data  (st.out_data),
    .idx   (st.out_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_q   <= '0;
      pend_q    <= '0;
      pend_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ifire) begin
            shift_q <= st.in_data;
            cnt     <= '0;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (done) begin
            // ifire here implies pend_full was 0, so the new frame bypasses pending.
            if (pend_full) begin
              shift_q   <= pend_q;
              pend_full <= 1'b0;
              cnt       <= '0;
            end else if (ifire) begin
              shift_q <= st.in_data;
              cnt     <= '0;
            end else begin
              shift_q <= '0;
              cnt     <= '0;
              state   <= IDLE;
            end
          end else begin
            if (ofire) cnt <= cnt + IW'(1);
            if (ifire) begin
              pend_q    <= st.in_data;
              pend_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_stream.sv
// Self-checking bench for p2s_stream: directed scenarios plus random traffic,
// scored against a beat-queue reference model.
module tb_p2s_stream;
  import fft_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned IW = $clog2(N);

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;

  p2s_stream_if #(.W(W), .N(N)) st ();

  p2s_stream #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .st    (st),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted frame becomes N expected beats in a queue.
  typedef struct {
    logic [W-1:0]  d;
    logic [IW-1:0] i;
    logic          f;
    logic          l;
  } beat_t;

  beat_t q[$];

  function automatic int unsigned lane_of(input int unsigned b);
    int unsigned r;
`ifdef P2S_BITREV_EN
    r = 0;
    for (int unsigned k = 0; k < IW; k++) begin
      if (((b >> k) & 1) != 0) r = r + (1 << (IW - 1 - k));
    end
`else
    r = b;
`endif
    return r;
  endfunction

  task automatic push_frame(input logic [N*W-1:0] f);
    beat_t bt;
    for (int unsigned b = 0; b < N; b++) begin
      bt.d = f[lane_of(b)*W +: W];
      bt.i = IW'(lane_of(b));
      bt.f = (b == 0);
      bt.l = (b == N - 1);
      q.push_back(bt);
    end
  endtask

  logic           rst_seen = 1'b0;
  logic           m_ifire, m_ofire, m_rst, m_flush;
  logic [N*W-1:0] m_data;

  always begin
    int unsigned held;
    logic exp_rdy;
    @(negedge clk);
    held    = (q.size() + N - 1) / N;
    exp_rdy = rst_n && (held < 2);
    check("in_ready", 32'(st.in_ready), 32'(exp_rdy));
    check("out_valid", 32'(st.out_valid), 32'(q.size() != 0));
    check("busy", 32'(busy), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_data", 32'(st.out_data), 32'(q[0].d));
      check("out_idx", 32'(st.out_idx), 32'(q[0].i));
      check("out_first", 32'(st.out_first), 32'(q[0].f));
      check("out_last", 32'(st.out_last), 32'(q[0].l));
    end
    if (rst_seen) begin
      check("rst_data", 32'(st.out_data), 32'h0);
      check("rst_idx", 32'(st.out_idx), 32'h0);
      check("rst_first", 32'(st.out_first), 32'h0);
      check("rst_last", 32'(st.out_last), 32'h0);
    end
    m_ifire = st.in_valid && exp_rdy;
    m_ofire = (q.size() != 0) && st.out_ready;
    m_rst   = rst_n;
    m_flush = flush;
    m_data  = st.in_data;
    @(posedge clk);
    if (!m_rst || m_flush) begin
      q.delete();
    end else begin
      if (m_ofire) void'(q.pop_front());
      if (m_ifire) push_frame(m_data);
    end
    rst_seen = !m_rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] mk(input logic [W-1:0] base);
    logic [N*W-1:0] f;
    for (int unsigned i = 0; i < N; i++) f[i*W +: W] = base + W'(i);
    return f;
  endfunction

  task automatic send(input logic [N*W-1:0] f);
    logic acc;
    int unsigned t;
    t = 0;
    st.in_valid = 1'b1;
    st.in_data  = f;
    forever begin
      @(negedge clk);
      acc = st.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        check("send_timeout", 32'(acc), 32'h1);
        break;
      end
    end
    st.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    st.in_valid  = 1'b0;
    st.in_data   = '0;
    st.out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // single frame, natural throughput
    st.out_ready = 1'b1;
    send(mk(16'h1000));
    repeat (10) tick();

    // back-to-back frames, no bubble
    send(mk(16'h0A00));
    send(mk(16'h0B00));
    repeat (20) tick();

    // stall pattern 1,0,0,1
    st.out_ready = 1'b0;
    send(mk(16'h0300));
    for (int unsigned i = 0; i < 40; i++) begin
      st.out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
    end
    st.out_ready = 1'b1;
    repeat (10) tick();

    // three frames against a stalled sink
    st.out_ready = 1'b0;
    send(mk(16'h4A00));
    send(mk(16'h4B00));
    st.in_valid = 1'b1;
    st.in_data  = mk(16'h4C00);
    repeat (3) tick();
    st.out_ready = 1'b1;
    send(mk(16'h4C00));
    repeat (30) tick();

    // flush on beat 3 with a frame pending
    send(mk(16'h5A00));
    send(mk(16'h5B00));
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    send(mk(16'h5C00));
    repeat (12) tick();

    // reset mid-frame at beat 5
    send(mk(16'h6000));
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send(mk(16'h7000));
    repeat (12) tick();

    // random traffic
    for (int unsigned c = 0; c < 1500; c++) begin
      st.in_valid = 1'($urandom % 2);
      for (int unsigned i = 0; i < N; i++) st.in_data[i*W +: W] = W'($urandom);
      st.out_ready = ($urandom % 4) != 0;
      flush        = ($urandom % 100) == 0;
      rst_n        = ($urandom % 300) != 0;
      tick();
    end

    st.in_valid  = 1'b0;
    flush        = 1'b0;
    rst_n        = 1'b1;
    st.out_ready = 1'b1;
    repeat (30) tick();
    check("drained", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/p2s_stream.md
Name: p2s_stream

Overview:
- Parametrised parallel-to-serial converter for FFT output frames.
- Accepts one N-lane frame of W-bit samples per handshake and emits it one sample per cycle on a valid/ready stream.
- Provides first/last/index sideband and a one-frame pending buffer, so back-to-back frames stream without bubbles.
- Sits between the butterfly/output stage of the FFT core and the serial result interface.

Parameters:
- W, 16, sample width in bits (>=1).
- N, 8, lanes per frame; power of two, >=2.
- IW, $clog2(N), lane index width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of all buffered frames
- in_valid  in  1  frame valid
- in_ready  out  1  frame accepted when in_valid && in_ready
- in_data  in  N*W  lane i = in_data[i*W +: W]
- out_valid  out  1  sample valid
- out_ready  in  1  downstream accepts sample
- out_data  out  W  current sample
- out_idx  out  IW  lane index of out_data
- out_first  out  1  first beat of frame
- out_last  out  1  last beat of frame
- busy  out  1  any frame held (shift or pending)

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (rst_n=0 at an edge): out_valid=0, out_data=0, out_idx=0, out_first=0, out_last=0, busy=0, both stages empty, beat counter=0.
- in_ready is forced 0 while rst_n=0.
- Storage:
  - shift stage (active frame + beat counter cnt, 0..N-1).
  - pending stage (one full frame + full flag).
- in_ready = !pend_full (combinational from registers only; no dependence on in_valid).
- Fire on output: ofire = out_valid && out_ready. Fire on input: ifire = in_valid && in_ready.
- Shift-stage FSM:
  - IDLE: out_valid=0.
  - STREAM: out_valid=1; out_data = lane sel(cnt); out_idx = sel(cnt); out_first = (cnt==0); out_last = (cnt==N-1).
  - On ofire with cnt<N-1: cnt++.
  - On ofire with cnt==N-1 (frame done):
    - load pending if pend_full;
    - else load the incoming frame if ifire;
    - else go to IDLE.
  - In IDLE, ifire loads the shift stage directly; pending stays empty.
  - In STREAM without frame done, ifire writes pending.
  - Loading the shift stage resets cnt=0.
- Latency: frame accepted at edge k gives first beat visible (out_valid=1) in cycle k+1 when idle.
- Throughput: with out_ready held 1, beat N-1 of frame A is followed immediately by beat 0 of frame B.
- Simultaneous frame done and ifire with pend_full: not possible, since in_ready=0.
- Simultaneous pending-to-shift transfer and ifire: transfer uses old pending; new frame goes to pending only when in_ready was 1 (pend_full=0), i.e. directly to shift as above.
- Stall: out_valid, out_data, out_idx, out_first and out_last hold stable while out_valid && !out_ready.
- flush=1 at an edge: both stages emptied, cnt=0, out_valid=0 next cycle; any ifire in that cycle is dropped. rst_n has priority over flush.
- Reset mid-frame discards all data; no partial frames are emitted afterwards.
- busy = shift stage occupied || pend_full.

Optional Feature:
- Macro P2S_BITREV_EN.
- Defined: sel(cnt) = bit-reverse of cnt over IW bits, so FFT bin order is natural on output; out_idx reports the reversed lane index.
- Undefined: sel(cnt)=cnt, giving natural lane order (lane 0 first); out_idx = cnt.
- Handshake and timing are identical in both builds.

Decomposition:
- Package fft_pkg holds:
  - SAMPLE_W=16 and FFT_N=8 defaults;
  - typedef sample_t (logic [SAMPLE_W-1:0]);
  - function bitrev(idx, width).
- One sub-module, p2s_lane_sel: combinational N:1 W-bit lane mux indexed by sel(cnt), with the bit-reversal applied under P2S_BITREV_EN.
- FSM, counter and pending buffer stay in p2s_stream.

Test Plan:
- Reset then single frame, lanes i=0x1000+i, out_ready=1 -> beats 0x1000..0x1007 on consecutive cycles starting one cycle after accept; first on 0x1000, last on 0x1007; busy drops after the last beat. Bitrev build: order 0x1000,0x1004,0x1002,0x1006,0x1001,0x1005,0x1003,0x1007.
- Two frames presented back-to-back (A lanes 0xA00+i, B lanes 0xB00+i), out_ready=1 -> 16 contiguous beats with no bubble; in_ready=0 while B is pending and A is still streaming.
- out_ready toggled 1,0,0,1 repeating -> each sample held stable during stall cycles; no duplicates or drops; out_idx sequence is 0..7.
- Three frames offered while out_ready=0 -> first two accepted, third sees in_ready=0 until A's last beat fires, then is accepted.
- flush asserted on beat 3 of a frame with a frame pending -> out_valid=0 next cycle, busy=0, in_ready=1; next frame streams from beat 0.
- rst_n=0 for one cycle mid-frame at beat 5 -> all outputs zero next cycle, in_ready=0 during reset; a new frame afterwards streams correctly from lane 0.
